// File: rtl/reg_arb_pkg.sv
// Shared types for the SD-host register-set arbiters: FSM states, port count
// and the command latched from the winning requester.
package reg_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  wnr;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
    } reg_cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector, shared by the SD-host arbiters.
module rr_pick2
    import reg_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last_grant,
    output logic                 valid,
    output logic                 grant
);

    assign valid = |req;
    // On a tie the port that did not win last time goes next.
    assign grant = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/reg_set_arbiter.sv
// Round-robin arbiter sharing the register-set access port between the host bus
// (port 0) and the SD engine (port 1). REG_ARB_LOCK_EN adds lock0/lock1 inputs.
module reg_set_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int DATA_W     = REG_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              wnr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wnr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
`ifdef REG_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              rs_req,
    output logic              rs_wnr,
    output logic [ADDR_W-1:0] rs_address,
    output logic [DATA_W-1:0] rs_data_in,
    input  logic [DATA_W-1:0] rs_data_out,
    output logic              busy
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    arb_state_t           state;
    reg_cmd_t             cmd;
    logic                 winner;
    logic                 last_grant;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] req_eff;
    logic                 pick_valid;
    logic                 pick_grant;

    assign req_vec = {req1, req0};

`ifdef REG_ARB_LOCK_EN
    logic                 locked;
    logic                 lock_port;
    logic [NUM_PORTS-1:0] lock_vec;

    assign lock_vec = {lock1, lock0};

    always_comb begin
        // NOTE: default first so every path assigns req_eff and no latch is inferred.
        req_eff = req_vec;
        if (locked && lock_vec[lock_port])
            req_eff = req_vec & (lock_port ? 2'b10 : 2'b01);
    end
`else
    assign req_eff = req_vec;
`endif

    rr_pick2 u_pick (
        .req        (req_eff),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd        <= '0;
            winner     <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            rs_req     <= 1'b0;
            rs_wnr     <= 1'b0;
            rs_address <= '0;
            rs_data_in <= '0;
`ifdef REG_ARB_LOCK_EN
            locked     <= 1'b0;
            lock_port  <= 1'b0;
`endif
        end else begin
            // NOTE: one-cycle strobes default low here; the case below raises them.
            rs_req <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            case (state)
                IDLE: begin
`ifdef REG_ARB_LOCK_EN
                    if (locked && !lock_vec[lock_port])
                        locked <= 1'b0;
`endif
                    // The cycle showing an ack still belongs to the finished transaction.
                    if (pick_valid && !(ack0 || ack1)) begin
                        winner <= pick_grant;
                        cmd    <= pick_grant ? '{wnr: wnr1, addr: addr1, wdata: wdata1}
                                             : '{wnr: wnr0, addr: addr0, wdata: wdata0};
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    rs_req     <= 1'b1;
                    rs_wnr     <= cmd.wnr;
                    rs_address <= cmd.addr;
                    rs_data_in <= cmd.wdata;
                    cnt        <= CNT_W'(RD_LATENCY - 1);
                    state      <= (RD_LATENCY > 1) ? WAIT : ACK;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1))
                        state <= ACK;
                end
                ACK: begin
                    if (winner) begin
                        ack1 <= 1'b1;
                        if (!cmd.wnr) rdata1 <= rs_data_out;
                    end else begin
                        ack0 <= 1'b1;
                        if (!cmd.wnr) rdata0 <= rs_data_out;
                    end
                    last_grant <= winner;
`ifdef REG_ARB_LOCK_EN
                    locked     <= lock_vec[winner];
                    lock_port  <= winner;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_set_arbiter.sv
// Directed bench: dut_a runs with RD_LATENCY=1, dut_b with RD_LATENCY=3;
// both share the requester inputs and the register-set read data.
`timescale 1ns/1ps
module tb_reg_set_arbiter;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic       req0, wnr0, req1, wnr1;
    logic [7:0] addr0, wdata0, addr1, wdata1, rs_data_out;
`ifdef REG_ARB_LOCK_EN
    logic       lock0, lock1;
`endif

    logic       ack0_a, ack1_a, rs_req_a, rs_wnr_a, busy_a;
    logic [7:0] rdata0_a, rdata1_a, rs_address_a, rs_data_in_a;
    logic       ack0_b, ack1_b, rs_req_b, rs_wnr_b, busy_b;
    logic [7:0] rdata0_b, rdata1_b, rs_address_b, rs_data_in_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_set_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset_a),
        .req0(req0), .wnr0(wnr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_a), .rdata0(rdata0_a),
        .req1(req1), .wnr1(wnr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_a), .rdata1(rdata1_a),
`ifdef REG_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .rs_req(rs_req_a), .rs_wnr(rs_wnr_a), .rs_address(rs_address_a),
        .rs_data_in(rs_data_in_a), .rs_data_out(rs_data_out), .busy(busy_a)
    );

    reg_set_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset_b),
        .req0(req0), .wnr0(wnr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(req1), .wnr1(wnr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_b), .rdata1(rdata1_b),
`ifdef REG_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .rs_req(rs_req_b), .rs_wnr(rs_wnr_b), .rs_address(rs_address_b),
        .rs_data_in(rs_data_in_b), .rs_data_out(rs_data_out), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        req0 = 1'b0; wnr0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; wnr1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        rs_data_out = 8'h00;
`ifdef REG_ARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif
        tick(); tick();
        n_checks++;
        if ({ack0_a, ack1_a, rs_req_a, rs_wnr_a, busy_a, rs_address_a, rs_data_in_a, rdata0_a, rdata1_a} !== 37'd0) begin
            n_fail++; $display("FAIL reset_a outputs got %b %b %b %b %b %h %h %h %h required all zero",
                ack0_a, ack1_a, rs_req_a, rs_wnr_a, busy_a, rs_address_a, rs_data_in_a, rdata0_a, rdata1_a);
        end
        n_checks++;
        if ({ack0_b, ack1_b, rs_req_b, rs_wnr_b, busy_b, rs_address_b, rs_data_in_b, rdata0_b, rdata1_b} !== 37'd0) begin
            n_fail++; $display("FAIL reset_b outputs got %b %b %b %b %b %h %h %h %h required all zero",
                ack0_b, ack1_b, rs_req_b, rs_wnr_b, busy_b, rs_address_b, rs_data_in_b, rdata0_b, rdata1_b);
        end
        reset_a = 1'b0; reset_b = 1'b0;
    endtask

    task automatic test_single_write();
        req0 = 1'b1; wnr0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h05;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (rs_req_a !== (c == 2)) begin
                n_fail++; $display("FAIL wr_rs_req c=%0d got %b required %b", c, rs_req_a, (c == 2));
            end
            n_checks++;
            if (ack0_a !== (c == 3)) begin
                n_fail++; $display("FAIL wr_ack0 c=%0d got %b required %b", c, ack0_a, (c == 3));
            end
            n_checks++;
            if (ack1_a !== 1'b0) begin
                n_fail++; $display("FAIL wr_ack1 c=%0d got %b required 0", c, ack1_a);
            end
            if (c == 1) begin
                n_checks++;
                if (busy_a !== 1'b1) begin
                    n_fail++; $display("FAIL wr_busy got %b required 1", busy_a);
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({rs_wnr_a, rs_address_a, rs_data_in_a} !== {1'b1, 8'h10, 8'h05}) begin
                    n_fail++; $display("FAIL wr_rs_cmd got wnr=%b addr=%h data=%h required 1 10 05",
                        rs_wnr_a, rs_address_a, rs_data_in_a);
                end
            end
            if (c == 3) req0 = 1'b0;
        end
    endtask

    task automatic test_read();
        idle_gap(8);
        rs_data_out = 8'h05;
        req1 = 1'b1; wnr1 = 1'b0; addr1 = 8'h10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (ack1_a !== (c == 3)) begin
                n_fail++; $display("FAIL rd_ack1 c=%0d got %b required %b", c, ack1_a, (c == 3));
            end
            if (c == 2) begin
                n_checks++;
                if ({rs_req_a, rs_wnr_a, rs_address_a} !== {1'b1, 1'b0, 8'h10}) begin
                    n_fail++; $display("FAIL rd_rs_cmd got req=%b wnr=%b addr=%h required 1 0 10",
                        rs_req_a, rs_wnr_a, rs_address_a);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (rdata1_a !== 8'h05) begin
                    n_fail++; $display("FAIL rd_rdata1 got %h required 05", rdata1_a);
                end
                req1 = 1'b0;
                rs_data_out = 8'hAA;
            end
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (rdata1_a !== 8'h05) begin
            n_fail++; $display("FAIL rd_hold_rdata1 got %h required 05", rdata1_a);
        end
        n_checks++;
        if (rdata0_a !== 8'h00) begin
            n_fail++; $display("FAIL rd_rdata0_untouched got %h required 00", rdata0_a);
        end
    endtask

    task automatic test_drop_early();
        idle_gap(6);
        rs_data_out = 8'h5A;
        req0 = 1'b1; wnr0 = 1'b0; addr0 = 8'h21;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) req0 = 1'b0;
            n_checks++;
            if (ack0_a !== (c == 3)) begin
                n_fail++; $display("FAIL drop_ack0 c=%0d got %b required %b", c, ack0_a, (c == 3));
            end
            if (c == 3) begin
                n_checks++;
                if (rdata0_a !== 8'h5A) begin
                    n_fail++; $display("FAIL drop_rdata0 got %h required 5a", rdata0_a);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        idle_gap(6);
        req0 = 1'b1; wnr0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h01;
        req1 = 1'b1; wnr1 = 1'b1; addr1 = 8'h30; wdata1 = 8'h02;
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            n_checks++;
            if (ack0_a !== (c % 8 == 3)) begin
                n_fail++; $display("FAIL sim_ack0 c=%0d got %b required %b", c, ack0_a, (c % 8 == 3));
            end
            n_checks++;
            if (ack1_a !== (c % 8 == 7)) begin
                n_fail++; $display("FAIL sim_ack1 c=%0d got %b required %b", c, ack1_a, (c % 8 == 7));
            end
            if (c % 4 == 2) begin
                n_checks++;
                if (rs_address_a !== ((c % 8 == 2) ? 8'h20 : 8'h30)) begin
                    n_fail++; $display("FAIL sim_rs_address c=%0d got %h required %h",
                        c, rs_address_a, ((c % 8 == 2) ? 8'h20 : 8'h30));
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_addr;
        idle_gap(6);
        req0 = 1'b1; wnr0 = 1'b1; addr0 = 8'h00; wdata0 = 8'h40;
        for (int c = 1; c <= 16; c++) begin
            tick();
            n_checks++;
            if (rs_req_a !== (c % 4 == 2)) begin
                n_fail++; $display("FAIL b2b_rs_req c=%0d got %b required %b", c, rs_req_a, (c % 4 == 2));
            end
            n_checks++;
            if ({ack0_a, ack1_a} !== {(c % 4 == 3), 1'b0}) begin
                n_fail++; $display("FAIL b2b_acks c=%0d got %b%b required %b0", c, ack0_a, ack1_a, (c % 4 == 3));
            end
            if (c % 4 == 2) begin
                exp_addr = 8'(c / 4);
                n_checks++;
                if ({rs_address_a, rs_data_in_a} !== {exp_addr, 8'h40 + exp_addr}) begin
                    n_fail++; $display("FAIL b2b_rs_cmd c=%0d got addr=%h data=%h required %h %h",
                        c, rs_address_a, rs_data_in_a, exp_addr, 8'h40 + exp_addr);
                end
            end
            if (c % 4 == 3) begin
                if (c == 15) begin
                    req0 = 1'b0;
                end else begin
                    addr0  = 8'(c / 4 + 1);
                    wdata0 = 8'h40 + 8'(c / 4 + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_gap(8);
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        rs_data_out = 8'h77;
        req1 = 1'b1; wnr1 = 1'b0; addr1 = 8'h33;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++;
            if ({ack0_b, ack1_b} !== 2'b00) begin
                n_fail++; $display("FAIL rstmid_pre_ack c=%0d got %b%b required 00", c, ack0_b, ack1_b);
            end
        end
        n_checks++;
        if ({busy_b, rs_address_b} !== {1'b1, 8'h33}) begin
            n_fail++; $display("FAIL rstmid_inflight got busy=%b addr=%h required 1 33", busy_b, rs_address_b);
        end
        req0 = 1'b1; wnr0 = 1'b1; addr0 = 8'h44; wdata0 = 8'h99;
        reset_b = 1'b1;
        tick();
        n_checks++;
        if ({ack0_b, ack1_b, rs_req_b, rs_wnr_b, busy_b, rs_address_b, rs_data_in_b, rdata0_b, rdata1_b} !== 37'd0) begin
            n_fail++; $display("FAIL rstmid_outputs got %b %b %b %b %b %h %h %h %h required all zero",
                ack0_b, ack1_b, rs_req_b, rs_wnr_b, busy_b, rs_address_b, rs_data_in_b, rdata0_b, rdata1_b);
        end
        reset_b = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if ({ack0_b, ack1_b} !== {(c == 5), (c == 11)}) begin
                n_fail++; $display("FAIL rstmid_acks c=%0d got %b%b required %b%b",
                    c, ack0_b, ack1_b, (c == 5), (c == 11));
            end
            if (c == 5) req0 = 1'b0;
            if (c == 11) begin
                n_checks++;
                if (rdata1_b !== 8'h77) begin
                    n_fail++; $display("FAIL rstmid_rdata1 got %h required 77", rdata1_b);
                end
                req1 = 1'b0;
            end
        end
    endtask

`ifdef REG_ARB_LOCK_EN
    task automatic test_lock();
        idle_gap(6);
        lock0 = 1'b1; lock1 = 1'b0;
        req0 = 1'b1; wnr0 = 1'b1; addr0 = 8'h50; wdata0 = 8'h11;
        req1 = 1'b1; wnr1 = 1'b1; addr1 = 8'h60; wdata1 = 8'h22;
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            n_checks++;
            if ({ack0_a, ack1_a} !== {(c == 3 || c == 7 || c == 11), (c == 15)}) begin
                n_fail++; $display("FAIL lock_acks c=%0d got %b%b required %b%b",
                    c, ack0_a, ack1_a, (c == 3 || c == 7 || c == 11), (c == 15));
            end
            if (c == 11) begin
                req0 = 1'b0; lock0 = 1'b0;
            end
        end
        req1 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_drop_early();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
`ifdef REG_ARB_LOCK_EN
        test_lock();
`endif
        idle_gap(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
